// File: rtl/cellrv32_npu_package.sv
// Shared types and defaults for the NPU matrix-multiply sequencer.
`default_nettype none

package cellrv32_npu_package;

  localparam int MATRIX_WIDTH_DEFAULT = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } matmul_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] len;
    logic        acc;
  } matmul_instr_t;

endpackage

`default_nettype wire

// File: rtl/cellrv32_npu_delay_line.sv
// DEPTH x WIDTH shift register with asynchronous active-low clear.
`default_nettype none

module cellrv32_npu_delay_line
  import cellrv32_npu_package::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [DEPTH*WIDTH-1:0] stage_q, stage_d;

  generate
    if (DEPTH == 1) begin : g_single
      always_comb stage_d = din_i;
    end else begin : g_chain
      always_comb stage_d = {stage_q[(DEPTH-1)*WIDTH-1:0], din_i};
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) stage_q <= '0;
    else         stage_q <= stage_d;
  end

  assign dout_o = stage_q[DEPTH*WIDTH-1 -: WIDTH];

endmodule

`default_nettype wire

// File: rtl/cellrv32_npu_matmul_control.sv
// Matmul pass sequencer: row issue, accumulator counter control, delayed write strobes.
// Optional busy-cycle counter enabled by CELLRV32_NPU_MATMUL_PERF_EN.
`default_nettype none

module cellrv32_npu_matmul_control
  import cellrv32_npu_package::*;
#(
  parameter int MATRIX_WIDTH = MATRIX_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH   = 32,
  parameter int LEN_WIDTH    = 16,
  parameter int RESULT_DELAY = MATRIX_WIDTH + 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  input  logic [LEN_WIDTH-1:0]  instr_len_i,
  input  logic                  instr_acc_i,
  output logic                  row_valid_o,
  output logic                  cnt_load_o,
  output logic [ADDR_WIDTH-1:0] cnt_start_val_o,
  output logic                  cnt_enable_o,
  output logic                  acc_wr_en_o,
  output logic                  acc_accumulate_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           perf_cycles_o
);

  localparam int DRAIN_W = $clog2(RESULT_DELAY + 1);
  localparam logic [DRAIN_W-1:0]   LAST_DRAIN = DRAIN_W'(RESULT_DELAY - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE    = LEN_WIDTH'(1);

  matmul_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  row_q, row_d;
  logic [DRAIN_W-1:0]    drain_q, drain_d;
  logic                  acc_q, acc_d;
  logic [1:0]            dl_out;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    acc_d   = acc_q;
    row_d   = row_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (instr_valid_i) begin
          addr_d  = instr_addr_i;
          len_d   = instr_len_i;
          acc_d   = instr_acc_i;
          row_d   = '0;
          drain_d = '0;
          state_d = (instr_len_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (row_q == len_q - LEN_ONE) begin
          row_d   = '0;
          state_d = DRAIN;
        end else begin
          row_d = row_q + LEN_ONE;
        end
      end
      DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          drain_d = '0;
          state_d = DONE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      acc_q   <= 1'b0;
      row_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      row_q   <= row_d;
      drain_q <= drain_d;
    end
  end

  // All strobes below decode registered state only; no input reaches an output.
  assign instr_ready_o   = (state_q == IDLE);
  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == DONE);
  assign row_valid_o     = (state_q == RUN);
  assign cnt_load_o      = (state_q == RUN) && (row_q == '0);
  assign cnt_enable_o    = (state_q == RUN) || (state_q == DRAIN);
  assign cnt_start_val_o = addr_q;

  cellrv32_npu_delay_line #(
    .DEPTH (RESULT_DELAY),
    .WIDTH (2)
  ) u_delay (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .din_i  ({acc_q & row_valid_o, row_valid_o}),
    .dout_o (dl_out)
  );

  assign acc_wr_en_o      = dl_out[0];
  assign acc_accumulate_o = dl_out[1] & dl_out[0];

`ifdef CELLRV32_NPU_MATMUL_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if ((state_q != IDLE) && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) perf_q <= '0;
    else         perf_q <= perf_d;
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cellrv32_npu_matmul_control.sv
// Directed self-checking bench for cellrv32_npu_matmul_control (RESULT_DELAY = 16).
`default_nettype none

module tb_cellrv32_npu_matmul_control;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_addr_i;
  logic [15:0] instr_len_i;
  logic        instr_acc_i;
  logic        row_valid_o, cnt_load_o, cnt_enable_o;
  logic [31:0] cnt_start_val_o;
  logic        acc_wr_en_o, acc_accumulate_o, busy_o, done_o;
  logic [31:0] perf_cycles_o;

  always #5 clk = ~clk;

  cellrv32_npu_matmul_control dut (
    .clk_i            (clk),
    .rstn_i           (rstn_i),
    .instr_valid_i    (instr_valid_i),
    .instr_ready_o    (instr_ready_o),
    .instr_addr_i     (instr_addr_i),
    .instr_len_i      (instr_len_i),
    .instr_acc_i      (instr_acc_i),
    .row_valid_o      (row_valid_o),
    .cnt_load_o       (cnt_load_o),
    .cnt_start_val_o  (cnt_start_val_o),
    .cnt_enable_o     (cnt_enable_o),
    .acc_wr_en_o      (acc_wr_en_o),
    .acc_accumulate_o (acc_accumulate_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .perf_cycles_o    (perf_cycles_o)
  );

`ifdef CELLRV32_NPU_MATMUL_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Observation index: 0 rv, 1 load, 2 enable, 3 wr, 4 accum, 5 done, 6 ready, 7 busy
  int first_c [8];
  int last_c  [8];
  int cnt_c   [8];
  logic [31:0] start_at_load;
  logic        end_ready;
  logic [31:0] end_start;
  logic [31:0] end_perf;
  logic [31:0] nxt_addr;
  logic [15:0] nxt_len;
  logic        nxt_acc;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] perf_exp(input int n);
    return PERF_ON ? 32'(n) : 32'd0;
  endfunction

  // Steps ncyc cycles, sampling each at the falling edge; optionally offers
  // new fields at cycle chg_at and drops valid at cycle drop_at.
  task automatic observe(input int ncyc, input int chg_at, input int drop_at);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) begin
      first_c[i] = 0; last_c[i] = 0; cnt_c[i] = 0;
    end
    start_at_load = 32'hDEAD_BEEF;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      v = {busy_o, instr_ready_o, done_o, acc_accumulate_o,
           acc_wr_en_o, cnt_enable_o, cnt_load_o, row_valid_o};
      if (cnt_load_o && cnt_c[1] == 0) start_at_load = cnt_start_val_o;
      for (int i = 0; i < 8; i++) begin
        if (v[i]) begin
          if (cnt_c[i] == 0) first_c[i] = k;
          last_c[i] = k;
          cnt_c[i]++;
        end
      end
      if (k == chg_at) begin
        instr_valid_i = 1'b1;
        instr_addr_i  = nxt_addr;
        instr_len_i   = nxt_len;
        instr_acc_i   = nxt_acc;
      end
      if (k == drop_at) instr_valid_i = 1'b0;
    end
    end_ready = instr_ready_o;
    end_start = cnt_start_val_o;
    end_perf  = perf_cycles_o;
  endtask

  task automatic offer(input logic [31:0] a, input logic [15:0] l, input logic c);
    instr_valid_i = 1'b1;
    instr_addr_i  = a;
    instr_len_i   = l;
    instr_acc_i   = c;
  endtask

  task automatic check_cleared(input string pfx);
    check_eq({pfx, "_ready"}, instr_ready_o, 1);
    check_eq({pfx, "_busy"},  busy_o, 0);
    check_eq({pfx, "_rv"},    row_valid_o, 0);
    check_eq({pfx, "_load"},  cnt_load_o, 0);
    check_eq({pfx, "_en"},    cnt_enable_o, 0);
    check_eq({pfx, "_wr"},    acc_wr_en_o, 0);
    check_eq({pfx, "_accum"}, acc_accumulate_o, 0);
    check_eq({pfx, "_done"},  done_o, 0);
    check_eq({pfx, "_start"}, cnt_start_val_o, 0);
    check_eq({pfx, "_perf"},  perf_cycles_o, 0);
  endtask

  initial begin
    rstn_i        = 1'b0;
    instr_valid_i = 1'b0;
    instr_addr_i  = '0;
    instr_len_i   = '0;
    instr_acc_i   = 1'b0;
    nxt_addr = '0; nxt_len = '0; nxt_acc = 1'b0;
    repeat (2) @(negedge clk);
    check_cleared("rst");
    rstn_i = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", instr_ready_o, 1);

    // Single pass addr=0x40 L=3 acc=0
    offer(32'h40, 16'd3, 1'b0);
    observe(21, 0, 1);
    check_eq("a_load_cnt",   cnt_c[1], 1);
    check_eq("a_load_cyc",   first_c[1], 1);
    check_eq("a_load_start", start_at_load, 32'h40);
    check_eq("a_rv_first",   first_c[0], 1);
    check_eq("a_rv_last",    last_c[0], 3);
    check_eq("a_rv_cnt",     cnt_c[0], 3);
    check_eq("a_en_first",   first_c[2], 1);
    check_eq("a_en_last",    last_c[2], 19);
    check_eq("a_en_cnt",     cnt_c[2], 19);
    check_eq("a_wr_first",   first_c[3], 17);
    check_eq("a_wr_last",    last_c[3], 19);
    check_eq("a_wr_cnt",     cnt_c[3], 3);
    check_eq("a_accum_cnt",  cnt_c[4], 0);
    check_eq("a_done_cyc",   first_c[5], 20);
    check_eq("a_done_cnt",   cnt_c[5], 1);
    check_eq("a_ready_cnt",  cnt_c[6], 1);
    check_eq("a_ready_end",  end_ready, 1);
    check_eq("a_busy_cnt",   cnt_c[7], 20);
    check_eq("a_start_end",  end_start, 32'h40);
    check_eq("a_perf",       end_perf, perf_exp(20));

    // Zero-length pass
    offer(32'h55, 16'd0, 1'b1);
    observe(2, 0, 1);
    check_eq("z_done_cyc",  first_c[5], 1);
    check_eq("z_done_cnt",  cnt_c[5], 1);
    check_eq("z_load_cnt",  cnt_c[1], 0);
    check_eq("z_en_cnt",    cnt_c[2], 0);
    check_eq("z_wr_cnt",    cnt_c[3], 0);
    check_eq("z_rv_cnt",    cnt_c[0], 0);
    check_eq("z_ready_end", end_ready, 1);
    check_eq("z_start",     end_start, 32'h55);
    check_eq("z_perf",      end_perf, perf_exp(21));

    // Back-to-back: L=2/acc=1 then L=1/acc=0 with valid held high
    offer(32'h100, 16'd2, 1'b1);
    nxt_addr = 32'h200; nxt_len = 16'd1; nxt_acc = 1'b0;
    observe(39, 1, 21);
    check_eq("b_load_cnt",   cnt_c[1], 2);
    check_eq("b_load2_cyc",  last_c[1], 21);
    check_eq("b_rv_cnt",     cnt_c[0], 3);
    check_eq("b_rv_last",    last_c[0], 21);
    check_eq("b_wr_cnt",     cnt_c[3], 3);
    check_eq("b_wr_first",   first_c[3], 17);
    check_eq("b_wr_last",    last_c[3], 37);
    check_eq("b_accum_cnt",  cnt_c[4], 2);
    check_eq("b_accum_last", last_c[4], 18);
    check_eq("b_done_first", first_c[5], 19);
    check_eq("b_done_last",  last_c[5], 38);
    check_eq("b_ready_cnt",  cnt_c[6], 2);
    check_eq("b_ready_end",  end_ready, 1);
    check_eq("b_start_end",  end_start, 32'h200);
    check_eq("b_perf",       end_perf, perf_exp(58));

    // Instruction offered mid-RUN must be ignored
    offer(32'h300, 16'd5, 1'b0);
    nxt_addr = 32'hABC; nxt_len = 16'd1; nxt_acc = 1'b1;
    observe(23, 2, 4);
    check_eq("i_rv_cnt",    cnt_c[0], 5);
    check_eq("i_rv_last",   last_c[0], 5);
    check_eq("i_load_cnt",  cnt_c[1], 1);
    check_eq("i_wr_cnt",    cnt_c[3], 5);
    check_eq("i_wr_last",   last_c[3], 21);
    check_eq("i_accum_cnt", cnt_c[4], 0);
    check_eq("i_done_cyc",  first_c[5], 22);
    check_eq("i_ready_cnt", cnt_c[6], 1);
    check_eq("i_start_end", end_start, 32'h300);
    check_eq("i_perf",      end_perf, perf_exp(80));

    // Reset in DRAIN of an L=4 pass
    offer(32'h480, 16'd4, 1'b1);
    observe(14, 0, 1);
    check_eq("r_busy_pre", busy_o, 1);
    check_eq("r_en_pre",   cnt_enable_o, 1);
    rstn_i = 1'b0;
    #1;
    check_cleared("r_mid");
    @(negedge clk);
    rstn_i = 1'b1;
    observe(25, 0, 0);
    check_eq("r_wr_cnt",    cnt_c[3], 0);
    check_eq("r_accum_cnt", cnt_c[4], 0);
    check_eq("r_en_cnt",    cnt_c[2], 0);
    check_eq("r_busy_cnt",  cnt_c[7], 0);
    check_eq("r_ready_cnt", cnt_c[6], 25);
    check_eq("r_perf",      end_perf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
